// File: rtl/run_sequencer.sv
// run_sequencer: host-side program launcher for a small processor.
//
// Accepts a host run request while idle, holds the processor start line for
// START_CYCLES cycles (PC reset), counts RUN cycles until the processor raises
// cpu_done, then presents the cycle count and program tag to the host until
// it is consumed. The count saturates rather than wrapping.
//
// Optional build macro: RUN_TIMEOUT_EN -- adds a RUN-cycle watchdog that ends
// the run after TIMEOUT cycles and flags it through timed_out. Without the
// macro RUN waits indefinitely and timed_out stays 0.
//
// Ports:
//   clk            in   sole clock, rising edge
//   reset          in   synchronous, active-high
//   run_req        in   host request to start a run (accepted only in IDLE)
//   prog_sel[1:0]  in   program tag, latched on acceptance
//   run_ack        out  one-cycle acceptance pulse (first START cycle)
//   cpu_start      out  processor start (PC load 0) during START
//   cpu_done       in   processor done flag, sampled only in RUN
//   busy           out  high in every state except IDLE
//   result_valid   out  result available, held until result_rdy
//   result_rdy     in   host consumes the result
//   result_cycles  out  RUN-cycle count of the last run (CNT_W bits)
//   result_prog    out  program tag of the last run
//   timed_out      out  last run ended by the watchdog
module run_sequencer #(
    parameter int START_CYCLES = 2,
    parameter int CNT_W        = 16,
    parameter int TIMEOUT      = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req,
    input  logic [1:0]       prog_sel,
    output logic             run_ack,
    output logic             cpu_start,
    input  logic             cpu_done,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_rdy,
    output logic [CNT_W-1:0] result_cycles,
    output logic [1:0]       result_prog,
    output logic             timed_out
);

    // A start length of 0 is promoted to 1 so the processor always sees a pulse.
    localparam int SC = (START_CYCLES < 1) ? 1 : START_CYCLES;
    localparam int SW = $clog2(SC + 1);
    localparam logic [SW-1:0] START_LAST = SW'(SC - 1);

`ifdef RUN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
`endif

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("run_sequencer: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        REPORT
    } state_e;

    state_e           state_q;
    logic [SW-1:0]    start_left_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       tag_q;

    logic             run_ack_q;
    logic             cpu_start_q;
    logic             busy_q;
    logic             result_valid_q;
    logic [CNT_W-1:0] result_cycles_q;
    logic [1:0]       result_prog_q;
    logic             timed_out_q;

    // Saturating increment: holds at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            start_left_q    <= '0;
            cnt_q           <= '0;
            tag_q           <= '0;
            run_ack_q       <= 1'b0;
            cpu_start_q     <= 1'b0;
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b0;
            result_cycles_q <= '0;
            result_prog_q   <= '0;
            timed_out_q     <= 1'b0;
        end else begin
            run_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (run_req) begin
                        tag_q        <= prog_sel;
                        start_left_q <= START_LAST;
                        cnt_q        <= '0;
                        run_ack_q    <= 1'b1;
                        cpu_start_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= START;
                    end
                end
                START: begin
                    // start_left_q counts the START cycles still to follow this one.
                    if (start_left_q == '0) begin
                        cpu_start_q <= 1'b0;
                        state_q     <= RUN;
                    end else begin
                        start_left_q <= start_left_q - SW'(1);
                    end
                end
                RUN: begin
                    if (cpu_done) begin
                        result_cycles_q <= cnt_q;
                        result_prog_q   <= tag_q;
                        timed_out_q     <= 1'b0;
                        result_valid_q  <= 1'b1;
                        state_q         <= REPORT;
                    end
`ifdef RUN_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        result_cycles_q <= TO_LAST;
                        result_prog_q   <= tag_q;
                        timed_out_q     <= 1'b1;
                        result_valid_q  <= 1'b1;
                        state_q         <= REPORT;
                    end
`endif
                    else begin
                        cnt_q <= cnt_d;
                    end
                end
                REPORT: begin
                    if (result_rdy) begin
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign run_ack       = run_ack_q;
    assign cpu_start     = cpu_start_q;
    assign busy          = busy_q;
    assign result_valid  = result_valid_q;
    assign result_cycles = result_cycles_q;
    assign result_prog   = result_prog_q;
    assign timed_out     = timed_out_q;

endmodule
